// File: rtl/chess_render_pipe.sv
// Chess board / sprite renderer: ROM address generation, piece map, cursor blink, palette.
// Latency: inputs at cycle T give registered RGB/out_valid at T+2+ROM_LATENCY, one pixel per clock.
// Backpressure: none; the pipeline never stalls and every input cycle produces one output cycle.
//
// Ports: vga_clk/reset_n (sync, active-low); hcount/vcount/pix_valid/mode are the pixel stream;
// pm_wr_* writes one piece-map square; cursor_* places the highlighted square; *_rom_addr/*_q
// form the external ROM loop; vga_r/g/b/out_valid are the registered pixel output.
module chess_render_pipe #(
    parameter int SCREEN_WIDTH   = 640,
    parameter int SCREEN_HEIGHT  = 480,
    parameter int COLOR_DEPTH    = 8,
    parameter int TILE_SIZE      = 56,
    parameter int BOARD_ORIGIN_X = 16,
    parameter int BOARD_ORIGIN_Y = 16,
    parameter int ROM_LATENCY    = 1,
    parameter int BLINK_FRAMES   = 30
) (
    input  logic                   vga_clk,
    input  logic                   reset_n,
    input  logic [9:0]             hcount,
    input  logic [9:0]             vcount,
    input  logic                   pix_valid,
    input  logic [1:0]             mode,
    input  logic                   pm_wr_en,
    input  logic [2:0]             pm_wr_row,
    input  logic [2:0]             pm_wr_col,
    input  logic [3:0]             pm_wr_piece,
    input  logic                   cursor_en,
    input  logic [2:0]             cursor_row,
    input  logic [2:0]             cursor_col,
    output logic [18:0]            scr_rom_addr,
    input  logic [1:0]             title_q,
    input  logic [1:0]             player_q,
    input  logic [1:0]             board_q,
    output logic [18:0]            piece_rom_addr,
    input  logic [1:0]             piece_q,
    output logic [COLOR_DEPTH-1:0] vga_r,
    output logic [COLOR_DEPTH-1:0] vga_g,
    output logic [COLOR_DEPTH-1:0] vga_b,
    output logic                   out_valid
);

    localparam logic [10:0] BX0 = 11'(BOARD_ORIGIN_X);
    localparam logic [10:0] BX1 = 11'(BOARD_ORIGIN_X + 8 * TILE_SIZE);
    localparam logic [10:0] BY0 = 11'(BOARD_ORIGIN_Y);
    localparam logic [10:0] BY1 = 11'(BOARD_ORIGIN_Y + 8 * TILE_SIZE);
    localparam int          CW  = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [3:0] BACK_W [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd2, 4'd1, 4'd0};
    localparam logic [3:0] BACK_B [8] = '{4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd8, 4'd7, 4'd6};

    // Per-pixel side information that travels alongside the ROM round trip.
    typedef struct packed {
        logic       vld;
        logic [1:0] mode;
        logic       hit;
        logic [3:0] idx;
        logic       cur;
        logic       blink;
    } meta_t;

    function automatic logic [3:0] pm_init(input int i);
        int r;
        int c;
        r = i / 8;
        c = i % 8;
        case (r)
            0:       pm_init = BACK_W[c];
            1:       pm_init = 4'd5;
            6:       pm_init = 4'd11;
            7:       pm_init = BACK_B[c];
            default: pm_init = 4'd15;
        endcase
    endfunction

    function automatic logic on_edge(input logic [9:0] r);
        on_edge = (r == 10'd0) || (r == 10'd1) ||
                  (r == 10'(TILE_SIZE - 2)) || (r == 10'(TILE_SIZE - 1));
    endfunction

    // Channels are 8-bit in the palette; rescale to the configured depth.
    function automatic logic [COLOR_DEPTH-1:0] scale(input logic [7:0] c);
        scale = COLOR_DEPTH'((32'(c) << COLOR_DEPTH) >> 8);
    endfunction

    logic [3:0]             pm_q [64];
    logic [1:0]             mode_q;
    logic [CW-1:0]          fcnt_q;
    logic                   blink_q;
    logic                   disp_blink_q;
    logic [18:0]            scr_addr_q, scr_addr_d;
    logic [18:0]            piece_addr_q, piece_addr_d;
    meta_t                  meta_q [0:ROM_LATENCY];
    meta_t                  meta_d;
    meta_t                  mo;
    logic [COLOR_DEPTH-1:0] r_q, g_q, b_q, r_d, g_d, b_d;
    logic                   vld_q;

    logic       frame_start;
    logic [1:0] eff_mode;
    logic       eff_blink;
    logic [9:0] off_x, off_y, rel_x, rel_y;
    logic [2:0] tile_col, tile_row;
    logic       board_hit;
    logic [3:0] idx;
    logic       cur_hit;
    logic       sprite;
    logic [2:0] pal_idx;
    logic [23:0] rgb;

    assign frame_start = pix_valid && (hcount == 10'd0) && (vcount == 10'd0);
    // The frame-start pixel already belongs to the new frame, so it sees the incoming mode.
    assign eff_mode    = frame_start ? mode : mode_q;
    // The displayed blink phase is the one in force when the frame began.
    assign eff_blink   = frame_start ? blink_q : disp_blink_q;

    assign off_x    = hcount - 10'(BOARD_ORIGIN_X);
    assign off_y    = vcount - 10'(BOARD_ORIGIN_Y);
    assign tile_col = 3'(off_x / 10'(TILE_SIZE));
    assign tile_row = 3'(off_y / 10'(TILE_SIZE));
    assign rel_x    = off_x % 10'(TILE_SIZE);
    assign rel_y    = off_y % 10'(TILE_SIZE);

    // Squares lying beyond the visible area never count as hits.
    assign board_hit = ({1'b0, hcount} >= BX0) && ({1'b0, hcount} < BX1) &&
                       ({1'b0, vcount} >= BY0) && ({1'b0, vcount} < BY1) &&
                       ({1'b0, hcount} < 11'(SCREEN_WIDTH)) &&
                       ({1'b0, vcount} < 11'(SCREEN_HEIGHT));

    // Reads see the pre-write contents when a write targets the same square.
    assign idx     = pm_q[{tile_row, tile_col}];
    assign cur_hit = cursor_en && board_hit && (tile_row == cursor_row) &&
                     (tile_col == cursor_col) && (on_edge(rel_x) || on_edge(rel_y));
    assign sprite  = (eff_mode == 2'b11) && board_hit && (idx < 4'd12);

    assign scr_addr_d   = 19'(vcount) * 19'(SCREEN_WIDTH) + 19'(hcount);
    assign piece_addr_d = sprite ? (19'(idx) * 19'(TILE_SIZE * TILE_SIZE) +
                                    19'(rel_y) * 19'(TILE_SIZE) + 19'(rel_x)) : 19'd0;

    always_comb begin
        meta_d       = '0;
        meta_d.vld   = pix_valid;
        meta_d.mode  = eff_mode;
        meta_d.hit   = board_hit;
        meta_d.idx   = idx;
        meta_d.cur   = cur_hit;
        meta_d.blink = eff_blink;
    end

    assign mo = meta_q[ROM_LATENCY];

    always_comb begin
        pal_idx = 3'd0;
        case (mo.mode)
            2'b00:   pal_idx = {1'b0, title_q};
            2'b01:   pal_idx = {1'b0, player_q};
            2'b10:   pal_idx = {1'b0, board_q};
            default: pal_idx = (mo.hit && (mo.idx < 4'd12) && (piece_q != 2'd0)) ?
                               {1'b0, piece_q} : {1'b0, board_q};
        endcase
        if (mo.cur && mo.blink && mo.mode[1])
            pal_idx = 3'd4;
        case (pal_idx)
            3'd0:    rgb = 24'hEEEED2;
            3'd1:    rgb = 24'h69923E;
            3'd2:    rgb = 24'h4B4847;
            3'd3:    rgb = 24'hFFFFFF;
            default: rgb = 24'hF6F669;
        endcase
        r_d = mo.vld ? scale(rgb[23:16]) : '0;
        g_d = mo.vld ? scale(rgb[15:8])  : '0;
        b_d = mo.vld ? scale(rgb[7:0])   : '0;
    end

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 64; i++) pm_q[i] <= pm_init(i);
            for (int i = 0; i <= ROM_LATENCY; i++) meta_q[i] <= '0;
            mode_q       <= 2'b00;
            fcnt_q       <= '0;
            blink_q      <= 1'b0;
            disp_blink_q <= 1'b0;
            scr_addr_q   <= '0;
            piece_addr_q <= '0;
            r_q          <= '0;
            g_q          <= '0;
            b_q          <= '0;
            vld_q        <= 1'b0;
        end else begin
            if (pm_wr_en)
                pm_q[{pm_wr_row, pm_wr_col}] <= pm_wr_piece;
            if (frame_start) begin
                mode_q       <= mode;
                disp_blink_q <= blink_q;
                if (fcnt_q == CW'(BLINK_FRAMES - 1)) begin
                    fcnt_q  <= '0;
                    blink_q <= ~blink_q;
                end else begin
                    fcnt_q  <= fcnt_q + 1'b1;
                end
            end
            meta_q[0] <= meta_d;
            for (int i = 1; i <= ROM_LATENCY; i++) meta_q[i] <= meta_q[i-1];
            scr_addr_q   <= scr_addr_d;
            piece_addr_q <= piece_addr_d;
            r_q          <= r_d;
            g_q          <= g_d;
            b_q          <= b_d;
            vld_q        <= mo.vld;
        end
    end

    assign scr_rom_addr   = scr_addr_q;
    assign piece_rom_addr = piece_addr_q;
    assign vga_r          = r_q;
    assign vga_g          = g_q;
    assign vga_b          = b_q;
    assign out_valid      = vld_q;

endmodule

// File: tb/tb_chess_render_pipe.sv
// Directed bench for chess_render_pipe with a scoreboard-based output monitor.
// Latency: every expected pixel is tagged with the cycle it must appear (issue + LAT + 2).
// Backpressure: none; the monitor checks every clock.
module tb_chess_render_pipe;

    localparam int LAT = 2;
    localparam logic [23:0] C0 = 24'hEEEED2;
    localparam logic [23:0] C1 = 24'h69923E;
    localparam logic [23:0] C2 = 24'h4B4847;
    localparam logic [23:0] C3 = 24'hFFFFFF;
    localparam logic [23:0] CY = 24'hF6F669;

    logic        vga_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  hcount = '0, vcount = '0;
    logic        pix_valid = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        pm_wr_en = 1'b0;
    logic [2:0]  pm_wr_row = '0, pm_wr_col = '0;
    logic [3:0]  pm_wr_piece = '0;
    logic        cursor_en = 1'b0;
    logic [2:0]  cursor_row = '0, cursor_col = '0;
    logic [18:0] scr_rom_addr, piece_rom_addr;
    logic [1:0]  title_q = 2'd1, player_q = 2'd2, board_q = 2'd0, piece_q = 2'd0;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        out_valid;
    logic [23:0] rgb;

    assign rgb = {vga_r, vga_g, vga_b};

    chess_render_pipe #(.ROM_LATENCY(LAT), .BLINK_FRAMES(2)) dut (
        .vga_clk(vga_clk), .reset_n(reset_n),
        .hcount(hcount), .vcount(vcount), .pix_valid(pix_valid), .mode(mode),
        .pm_wr_en(pm_wr_en), .pm_wr_row(pm_wr_row), .pm_wr_col(pm_wr_col),
        .pm_wr_piece(pm_wr_piece),
        .cursor_en(cursor_en), .cursor_row(cursor_row), .cursor_col(cursor_col),
        .scr_rom_addr(scr_rom_addr), .title_q(title_q), .player_q(player_q),
        .board_q(board_q), .piece_rom_addr(piece_rom_addr), .piece_q(piece_q),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .out_valid(out_valid)
    );

    always #5 vga_clk = ~vga_clk;

    int cyc = 0;
    always @(posedge vga_clk) cyc <= cyc + 1;

    typedef struct {
        logic [23:0] rgb;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Output monitor: pops one expectation per valid output.
    initial begin
        exp_t e;
        forever begin
            @(posedge vga_clk);
            #1;
            if (out_valid) begin
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_out_valid: got rgb %06h with no pending pixel (cycle %0d)", rgb, cyc);
                end else begin
                    e = sb.pop_front();
                    if (rgb != e.rgb) begin
                        n_fail++;
                        $display("FAIL rgb: got %06h expected %06h (cycle %0d)", rgb, e.rgb, cyc);
                    end
                    n_chk++;
                    if (cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL out_cycle: got %0d expected %0d", cyc, e.cyc);
                    end
                end
            end else begin
                n_chk++;
                if (rgb != 24'h0) begin
                    n_fail++;
                    $display("FAIL idle_rgb: got %06h expected 000000 (cycle %0d)", rgb, cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, %0d pending", sb.size());
        $fatal(1, "watchdog");
    end

    // One pixel per call; exp_sa < 0 skips the screen-address check.
    task automatic pix(input int h, input int v, input logic [23:0] exp, input int exp_pa, input int exp_sa);
        exp_t e;
        @(negedge vga_clk);
        hcount    = 10'(h);
        vcount    = 10'(v);
        pix_valid = 1'b1;
        e.rgb = exp;
        e.cyc = cyc + LAT + 2;
        sb.push_back(e);
        @(posedge vga_clk);
        #1;
        chk($sformatf("piece_addr(%0d,%0d)", h, v), int'(piece_rom_addr), exp_pa);
        if (exp_sa >= 0)
            chk($sformatf("scr_addr(%0d,%0d)", h, v), int'(scr_rom_addr), exp_sa);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge vga_clk);
            pix_valid = 1'b0;
            hcount    = 10'd700;
            vcount    = 10'd0;
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge vga_clk);
            reset_n   = 1'b0;
            pix_valid = 1'b1;
            hcount    = 10'd101;
            vcount    = 10'd100;
            @(posedge vga_clk);
            #1;
            chk("rst_out_valid", int'(out_valid), 0);
            chk("rst_rgb", int'(rgb), 0);
            chk("rst_scr_addr", int'(scr_rom_addr), 0);
            chk("rst_piece_addr", int'(piece_rom_addr), 0);
        end
        reset_n   = 1'b1;
        pix_valid = 1'b0;
    endtask

    initial begin
        do_reset(3);

        // Title and player screens.
        mode = 2'b00;
        pix(0, 0, C1, 0, 0);
        pix(3, 2, C1, 0, 1283);
        idle(2);
        mode = 2'b01;
        pix(0, 0, C2, 0, 0);
        pix(100, 50, C2, 0, 32100);

        // Board + pieces: addressing and board edges, piece_q = 0 falls back to board_q.
        mode = 2'b11;
        pix(0, 0, C0, 0, 0);
        pix(16, 16, C0, 0, -1);
        pix(72, 16, C0, 3136, -1);
        pix(463, 16, C0, 55, -1);
        pix(464, 16, C0, 0, -1);
        pix(15, 16, C0, 0, -1);
        pix(16, 463, C0, 21896, -1);
        pix(16, 464, C0, 0, -1);
        idle(LAT + 3);
        piece_q = 2'd3;
        pix(130, 16, C3, 6274, -1);
        pix(16, 128, C0, 0, -1);
        pix(600, 16, C0, 0, -1);

        // Piece-map write: same-cycle read sees the old (empty) square.
        pm_wr_en = 1'b1; pm_wr_row = 3'd2; pm_wr_col = 3'd0; pm_wr_piece = 4'd5;
        pix(16, 128, C0, 0, -1);
        pm_wr_en = 1'b0;
        pix(16, 128, C3, 15680, -1);
        pix(100, 100, C3, 17276, -1);

        // Mode change mid-frame takes effect only at the next frame start.
        idle(LAT + 3);
        board_q = 2'd1;
        title_q = 2'd0;
        mode = 2'b10;
        pix(0, 0, C1, 0, 0);
        mode = 2'b00;
        pix(300, 300, C1, 0, -1);
        pix(301, 300, C1, 0, -1);
        pix(0, 0, C0, 0, 0);
        pix(300, 300, C0, 0, -1);

        // Reset mid-line while valid pixels are in flight.
        mode = 2'b11;
        pix(0, 0, C1, 0, 0);
        for (int i = 0; i < LAT + 3; i++) pix(100, 100, C3, 17276, -1);
        while (sb.size() > 0 && sb[$].cyc >= cyc + 1) void'(sb.pop_back());
        do_reset(2);

        // Latched mode is back to title until a frame start.
        mode = 2'b11;
        pix(300, 300, C0, 0, -1);

        // Cursor blink with BLINK_FRAMES=2: frames 2-3 highlighted.
        cursor_en = 1'b1; cursor_row = 3'd0; cursor_col = 3'd0;
        mode = 2'b10;
        for (int k = 0; k < 6; k++) begin
            pix(0, 0, C1, 0, 0);
            pix(17, 17, (k == 2 || k == 3) ? CY : C1, 0, -1);
            if (k == 2) begin
                pix(18, 18, C1, 0, -1);
                pix(70, 30, CY, 0, -1);
                pix(72, 17, C1, 0, -1);
            end
            idle(1);
        end

        // Piece map restored to the opening layout by reset.
        mode = 2'b11;
        pix(0, 0, C1, 0, 0);
        pix(16, 128, C1, 0, -1);
        pix(100, 100, C3, 17276, -1);

        idle(LAT + 4);
        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
